// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with branch conditions, call/return stack, trap vector and stall.
// Drives the fetch address and flags an IF/ID flush on every redirect.
module pc_sequencer #(
   parameter int XLEN = 16,
   parameter int INSTR_BYTES = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR = 'h0004,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            trap,
   input  logic            jump,
   input  logic            call,
   input  logic            ret,
   input  logic            branch,
   input  logic [2:0]      br_cond,
   input  logic            zero,
   input  logic            neg,
   input  logic            carry,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] link_addr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] next_pc,
   output logic            flush,
   output logic            ras_overflow,
   output logic            ras_underflow
);
   localparam int AW = $clog2(RAS_DEPTH);
   logic [XLEN-1:0] ras [RAS_DEPTH];
   logic [AW-1:0]   ptr;
   logic [AW:0]     cnt;
   logic            cond, taken, redirect, push, pop, empty, full;
   logic [XLEN-1:0] top;
   always_comb begin
      // odd br_cond codes are the negation of the even code below them; 11x is ALWAYS/NEVER
      cond = br_cond[2:1] == 2'd0 ? zero : br_cond[2:1] == 2'd1 ? neg : br_cond[2:1] == 2'd2 ? carry : 1'b1;
      taken = branch && (cond ^ br_cond[0]);
      empty = cnt == '0;
      full = cnt == (AW+1)'(RAS_DEPTH);
      top = ras[ptr - AW'(1)];
      push = call && !trap && !ret;
      pop = ret && !trap;
      redirect = trap | ret | jump | call | taken;
      next_pc = trap ? TRAP_VECTOR :
                ret ? (empty ? jump_target : top) :
                (jump | call) ? jump_target :
                taken ? branch_target :
                stall ? pc : pc + XLEN'(INSTR_BYTES);
      flush = rst_n & redirect;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VECTOR;
         ptr <= '0;
         cnt <= '0;
         ras_overflow <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         pc <= next_pc;
         ras_overflow <= push && full;
         ras_underflow <= pop && empty;
         if (push) begin
            ptr <= ptr + AW'(1);
            cnt <= full ? cnt : cnt + (AW+1)'(1);
         end else if (pop && !empty) begin
            ptr <= ptr - AW'(1);
            cnt <= cnt - (AW+1)'(1);
         end
      end
   end
   // when full, ptr already points at the oldest entry, so a push overwrites it
   always_ff @(posedge clk) begin
      if (push) ras[ptr] <= link_addr;
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; an independent model queues expected pc/pulses per cycle.
module tb_pc_sequencer;
   typedef struct {
      logic [15:0] pc;
      logic        ovf;
      logic        unf;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n, stall, trap, jump, call, ret, branch, zero, neg, carry;
   logic [2:0]  br_cond;
   logic [15:0] branch_target, jump_target, link_addr;
   logic [15:0] pc, next_pc;
   logic        flush, ras_overflow, ras_underflow;
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] m_pc;
   logic [15:0] mras [$];
   exp_t        sb [$];

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap), .jump(jump), .call(call),
      .ret(ret), .branch(branch), .br_cond(br_cond), .zero(zero), .neg(neg), .carry(carry),
      .branch_target(branch_target), .jump_target(jump_target), .link_addr(link_addr),
      .pc(pc), .next_pc(next_pc), .flush(flush),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      stall = 0; trap = 0; jump = 0; call = 0; ret = 0; branch = 0;
      br_cond = 3'd0; zero = 0; neg = 0; carry = 0;
      branch_target = 16'h0; jump_target = 16'h0; link_addr = 16'h0;
   endtask

   task automatic tick();
      logic        t;
      logic [15:0] np;
      exp_t        e;
      case (br_cond)
         3'd0: t = zero;
         3'd1: t = !zero;
         3'd2: t = neg;
         3'd3: t = !neg;
         3'd4: t = carry;
         3'd5: t = !carry;
         3'd6: t = 1'b1;
         default: t = 1'b0;
      endcase
      t = t & branch;
      if (trap) np = 16'h0004;
      else if (ret) np = (mras.size() == 0) ? jump_target : mras[$];
      else if (jump | call) np = jump_target;
      else if (t) np = branch_target;
      else if (stall) np = m_pc;
      else np = m_pc + 16'd2;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (!trap) begin
         if (ret) begin
            if (mras.size() > 0) void'(mras.pop_back());
            else e.unf = 1'b1;
         end else if (call) begin
            mras.push_back(link_addr);
            if (mras.size() > 4) begin
               void'(mras.pop_front());
               e.ovf = 1'b1;
            end
         end
      end
      #1;
      chk("flush", flush, trap | ret | jump | call | t);
      chk("next_pc", next_pc, np);
      m_pc = np;
      e.pc = np;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard: no expected entry");
      end else begin
         e = sb.pop_front();
         chk("pc", pc, e.pc);
         chk("ras_overflow", ras_overflow, e.ovf);
         chk("ras_underflow", ras_underflow, e.unf);
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      jump = 1'b1;
      jump_target = 16'h1234;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pc", pc, 16'h0000);
      chk("reset_flush", flush, 1'b0);
      chk("reset_ovf", ras_overflow, 1'b0);
      chk("reset_unf", ras_underflow, 1'b0);
      m_pc = 16'h0000;
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      tick();
      // T1 sequential fetch
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); idle(); tick();
      end
      // T2 stall at 0006, then branch overrides stall
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); stall = 1; tick();
      end
      @(negedge clk); idle(); stall = 1; branch = 1; br_cond = 3'd0; zero = 1; branch_target = 16'h0040; tick();
      // T3 every condition with each flag value
      for (int bc = 0; bc < 8; bc++) begin
         for (int f = 0; f < 2; f++) begin
            @(negedge clk); idle();
            branch = 1; br_cond = 3'(bc);
            zero = f[0]; neg = f[0]; carry = f[0];
            branch_target = 16'h0100 + 16'(bc * 16) + 16'(f * 2);
            tick();
         end
      end
      // T4 five calls into a depth-4 stack, then five rets
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); idle(); call = 1;
         link_addr = 16'(i * 256 + 2); jump_target = 16'h2000 + 16'(i * 16);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle(); ret = 1; jump_target = 16'h0EEE; tick();
      end
      @(negedge clk); idle(); ret = 1; jump_target = 16'h0FF0; tick();
      @(negedge clk); idle(); tick();
      // T5 trap beats call and branch; ret beats call
      @(negedge clk); idle(); trap = 1; call = 1; link_addr = 16'h0777; jump_target = 16'h3000;
      branch = 1; br_cond = 3'd6; branch_target = 16'h3100; tick();
      @(negedge clk); idle(); call = 1; link_addr = 16'h0600; jump_target = 16'h3200; tick();
      @(negedge clk); idle(); ret = 1; call = 1; link_addr = 16'h0999; jump_target = 16'h3300; tick();
      @(negedge clk); idle(); ret = 1; jump_target = 16'h3400; tick();
      @(negedge clk); idle(); jump = 1; call = 1; link_addr = 16'h0888; jump_target = 16'h3500; tick();
      @(negedge clk); idle(); ret = 1; branch = 1; br_cond = 3'd6; branch_target = 16'h3600; tick();
      // T6 wraparound
      @(negedge clk); idle(); jump = 1; jump_target = 16'hFFFC; tick();
      @(negedge clk); idle(); tick();
      @(negedge clk); idle(); tick();
      // reset asserted mid-call with a full stack and a live overflow pulse
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); idle(); call = 1; link_addr = 16'h0A00 + 16'(i); jump_target = 16'h4000 + 16'(i * 4); tick();
      end
      @(negedge clk); idle(); call = 1; link_addr = 16'h0BBB; jump_target = 16'h5000;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pc", pc, 16'h0000);
      chk("midrst_flush", flush, 1'b0);
      chk("midrst_ovf", ras_overflow, 1'b0);
      chk("midrst_unf", ras_underflow, 1'b0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      m_pc = 16'h0000;
      mras.delete();
      sb.delete();
      tick();
      @(negedge clk); idle(); ret = 1; jump_target = 16'h0ABC; tick();
      @(negedge clk); idle(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
